// File: rtl/cnn_pkg.sv
// Shared CNN definitions: pixel width, Q8.8 fraction bits and the pixel type.
package cnn_pkg;

  localparam int DATA_W = 16;
  localparam int Q_FRAC = 8;

  typedef logic signed [DATA_W-1:0] pixel_t;

endpackage

// File: rtl/maxpool_2x2_comparator.sv
// Signed two's-complement maximum of two pixels; equal operands give that value.
module maxpool_2x2_comparator
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [DATA_W-1:0] max_val
);

  // Select the larger operand; ties return a, which equals b.
  always_comb begin
    max_val = (a >= b) ? a : b;
  end

endmodule

// File: rtl/maxpool_2x2.sv
// Streaming 2x2 / stride-2 max pooling over a row-major IMG_W x IMG_H frame.
// Even rows fold horizontal pairs into a half-width line buffer; odd rows fold
// the buffered pair with the current pair and emit one pooled value per window.
// Optional macro POOL_RELU_EN clamps negative pooled results to zero.
module maxpool_2x2
  import cnn_pkg::*;
#(
  parameter int DATA_W = cnn_pkg::DATA_W,
  parameter int IMG_W  = 28,
  parameter int IMG_H  = 28
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int LW = (IMG_W > 2) ? $clog2(IMG_W / 2) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

  logic [CW-1:0]             col;
  logic [RW-1:0]             row;
  logic signed [DATA_W-1:0]  h;
  logic signed [DATA_W-1:0]  lbuf [IMG_W/2];
  logic [LW-1:0]             lidx;
  logic signed [DATA_W-1:0]  pix;
  logic signed [DATA_W-1:0]  lbuf_rd;
  logic signed [DATA_W-1:0]  max_h;
  logic signed [DATA_W-1:0]  max_l;
  logic signed [DATA_W-1:0]  pooled;
  logic                      in_fire;
  logic                      win_done;
  logic                      frame_end;

  assign pix       = in_data;
  assign lidx      = LW'(col >> 1);
  assign lbuf_rd   = lbuf[lidx];
  assign in_ready  = !(out_valid && !out_ready);
  assign in_fire   = in_valid && in_ready;
  assign win_done  = in_fire && row[0] && col[0];
  assign frame_end = (col == COL_LAST) && (row == ROW_LAST);

  maxpool_2x2_comparator #(.DATA_W(DATA_W)) u_cmp_h (
    .a       (h),
    .b       (pix),
    .max_val (max_h)
  );

  maxpool_2x2_comparator #(.DATA_W(DATA_W)) u_cmp_l (
    .a       (lbuf_rd),
    .b       (pix),
    .max_val (max_l)
  );

`ifdef POOL_RELU_EN
  maxpool_2x2_comparator #(.DATA_W(DATA_W)) u_cmp_relu (
    .a       (max_h),
    .b       ('0),
    .max_val (pooled)
  );
`else
  assign pooled = max_h;
`endif

  // Pixel position counters; advance only on accepted pixels, frames run back to back.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (in_fire) begin
      if (col == COL_LAST) begin
        col <= '0;
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end else begin
        col <= col + 1'b1;
      end
    end
  end

  // Holding register: raw pixel on even rows, vertical pair max on odd rows.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h <= '0;
    end else if (in_fire && !col[0]) begin
      h <= row[0] ? max_l : pix;
    end
  end

  // Line buffer keeps the horizontal pair max of each even row; no reset needed
  // because every entry is written on the even row before the odd row reads it.
  always_ff @(posedge clk) begin
    if (in_fire && !row[0] && col[0]) begin
      lbuf[lidx] <= max_h;
    end
  end

  // Output register: a completing window reloads it, otherwise a handshake drains it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else if (win_done) begin
      out_valid <= 1'b1;
      out_data  <= pooled;
      out_last  <= frame_end;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_maxpool_2x2.sv
// Directed bench for maxpool_2x2 on a 4x4 frame; honours POOL_RELU_EN if defined.
module tb_maxpool_2x2;

  localparam int DW = 16;
  localparam int IW = 4;
  localparam int IH = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [DW-1:0] in_data = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [DW-1:0] out_data;
  logic          out_last;

  typedef struct packed {
    logic          last;
    logic [DW-1:0] data;
  } beat_t;

  beat_t       q[$];
  int          n_asserts = 0;
  int          n_fail = 0;
  logic [15:0] frame [16];
  logic [15:0] exp_d [8];
  logic        exp_l [8];

  maxpool_2x2 #(.DATA_W(DW), .IMG_W(IW), .IMG_H(IH)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  always #5 clk = ~clk;

  // Record every output handshake, sampled well after the falling edge.
  always @(negedge clk) begin
    #2;
    if (!rst && out_valid && out_ready) q.push_back({out_last, out_data});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    n_asserts++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, $signed(got), got, $signed(want), want);
    end
  endtask

  task automatic send(input logic [15:0] v);
    int   n;
    logic r;
    n = 0;
    in_valid = 1'b1;
    in_data  = v;
    forever begin
      #1 r = in_ready;
      @(posedge clk);
      @(negedge clk);
      if (r) break;
      n++;
      if (n >= 50) begin
        n_asserts++;
        n_fail++;
        $error("FAIL send_timeout: observed in_ready=0 for %0d cycles expected acceptance", n);
        break;
      end
    end
  endtask

  task automatic send_frame();
    for (int i = 0; i < 16; i++) send(frame[i]);
  endtask

  task automatic end_frame();
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic check_outputs(input string tag, input int n);
    check({tag, "_count"}, 16'(q.size()), 16'(n));
    for (int i = 0; i < n && i < q.size(); i++) begin
      check($sformatf("%s_data%0d", tag, i), q[i].data, exp_d[i]);
      check($sformatf("%s_last%0d", tag, i), 16'(q[i].last), 16'(exp_l[i]));
    end
    q.delete();
  endtask

  task automatic set_ramp();
    for (int i = 0; i < 16; i++) frame[i] = 16'((i + 1) * 256);
    exp_d[0] = 16'd1536; exp_d[1] = 16'd2048; exp_d[2] = 16'd3584; exp_d[3] = 16'd4096;
    exp_d[4] = 16'd1536; exp_d[5] = 16'd2048; exp_d[6] = 16'd3584; exp_d[7] = 16'd4096;
    for (int i = 0; i < 8; i++) exp_l[i] = (i == 3) || (i == 7);
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_out_last", 16'(out_last), 16'd0);
    check("rst_out_data", out_data, 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    rst = 1'b0;
    @(negedge clk);

    // Ramp frame
    set_ramp();
    send_frame();
    end_frame();
    check_outputs("ramp", 4);

    // Negative values
    for (int i = 0; i < 16; i++) frame[i] = 16'(-512);
    frame[1] = 16'(-128);
`ifdef POOL_RELU_EN
    for (int i = 0; i < 4; i++) exp_d[i] = 16'd0;
`else
    exp_d[0] = 16'(-128); exp_d[1] = 16'(-512); exp_d[2] = 16'(-512); exp_d[3] = 16'(-512);
`endif
    for (int i = 0; i < 4; i++) exp_l[i] = (i == 3);
    send_frame();
    end_frame();
    check_outputs("neg", 4);

    // Backpressure on the first output
    set_ramp();
    for (int i = 0; i < 5; i++) send(frame[i]);
    out_ready = 1'b0;
    send(frame[5]);
    check("bp_first_valid", 16'(out_valid), 16'd1);
    in_valid = 1'b1;
    in_data  = frame[6];
    repeat (5) begin
      #1;
      check("bp_in_ready", 16'(in_ready), 16'd0);
      check("bp_out_valid", 16'(out_valid), 16'd1);
      check("bp_out_data", out_data, 16'd1536);
      check("bp_out_last", 16'(out_last), 16'd0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    for (int i = 6; i < 16; i++) send(frame[i]);
    end_frame();
    check_outputs("bp", 4);

    // Reset in the middle of a frame
    for (int i = 0; i < 6; i++) send(frame[i]);
    check("mid_pre_valid", 16'(out_valid), 16'd1);
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_data", out_data, 16'd0);
    repeat (2) @(negedge clk);
    check("mid_rst_valid_hold", 16'(out_valid), 16'd0);
    rst = 1'b0;
    q.delete();
    @(negedge clk);
    send_frame();
    end_frame();
    check_outputs("mid", 4);

    // Two frames back to back with in_valid held high
    send_frame();
    send_frame();
    end_frame();
    check_outputs("b2b", 8);

    // All pixels equal
    for (int i = 0; i < 16; i++) frame[i] = 16'd1792;
    for (int i = 0; i < 4; i++) begin
      exp_d[i] = 16'd1792;
      exp_l[i] = (i == 3);
    end
    send_frame();
    end_frame();
    check_outputs("equal", 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
